// File: rtl/ram_shift_reg_dual_tap.sv
// ram_shift_reg_dual_tap: RAM circular-buffer delay line with two registered, independently delayed taps
// Ports: clk, Reset (async active-low), CE (shift/read enable), SCLR (sync clear), SSET (sync set),
//        Din (data in), ADDR_A/ADDR_B (tap delays, clamped to WDEPTH-1),
//        Q_A/Q_B (registered tap data), VALID_A/VALID_B (tap holds real shifted data)
module ram_shift_reg_dual_tap #(
  parameter int DSIZE     = 8,
  parameter int WDEPTH    = 16,
  parameter int ADDR_MODE = 0,
  parameter int ASIZE     = $clog2(WDEPTH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             CE,
  input  logic             SCLR,
  input  logic             SSET,
  input  logic [DSIZE-1:0] Din,
  input  logic [ASIZE-1:0] ADDR_A,
  input  logic [ASIZE-1:0] ADDR_B,
  output logic [DSIZE-1:0] Q_A,
  output logic [DSIZE-1:0] Q_B,
  output logic             VALID_A,
  output logic             VALID_B
);
  localparam logic [ASIZE:0]   DEPTH = (ASIZE+1)'(WDEPTH);
  localparam logic [ASIZE-1:0] LAST  = ASIZE'(WDEPTH-1);
  logic [DSIZE-1:0] mem [WDEPTH];
  logic [ASIZE-1:0] wp_q, wp_d;
  logic [1:0][ASIZE-1:0] addr;
  logic [1:0][DSIZE-1:0] q;
  logic [1:0] valid;
  logic wr;
  assign addr    = {ADDR_B, ADDR_A};
  assign Q_A     = q[0];
  assign Q_B     = q[1];
  assign VALID_A = valid[0];
  assign VALID_B = valid[1];
  assign wr      = CE && !SCLR && !SSET;
  always_comb wp_d = SCLR ? '0 : !wr ? wp_q : (wp_q == LAST) ? '0 : wp_q + 1'b1;
  always_ff @(posedge clk) if (wr) mem[wp_q] <= Din;
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) wp_q <= '0;
    else wp_q <= wp_d;
  for (genvar t = 0; t < 2; t++) begin : g_tap
    logic [ASIZE-1:0] d, rd, addr_q;
    logic [ASIZE:0] fill_q, fill_d, fill_inc;
    logic [DSIZE-1:0] q_q, q_d, rdata;
    logic vld_q, vld_d, vld_n, flush;
    always_comb begin
      d        = ({1'b0, addr[t]} >= DEPTH) ? LAST : addr[t];
      // modulo subtraction that also works when WDEPTH is not a power of two
      rd       = (wp_q >= d) ? wp_q - d : ASIZE'({1'b0, wp_q} + DEPTH - {1'b0, d});
      // delay 0 bypasses the RAM: the sample being written this edge is the answer
      rdata    = (d == '0) ? Din : mem[rd];
      flush    = (ADDR_MODE != 0) && (addr[t] != addr_q);
      fill_inc = (fill_q == DEPTH) ? fill_q : fill_q + 1'b1;
      vld_n    = fill_inc > {1'b0, d};
      fill_d   = (SCLR || flush) ? '0 : !wr ? fill_q : fill_inc;
      vld_d    = (SCLR || flush) ? 1'b0 : !wr ? vld_q : vld_n;
      q_d      = SCLR ? '0 : SSET ? '1 : flush ? '0 : !CE ? q_q : vld_n ? rdata : '0;
    end
    always_ff @(posedge clk or negedge Reset)
      if (!Reset) begin
        addr_q <= '0;
        fill_q <= '0;
        vld_q  <= 1'b0;
        q_q    <= '0;
      end else begin
        addr_q <= addr[t];
        fill_q <= fill_d;
        vld_q  <= vld_d;
        q_q    <= q_d;
      end
    assign q[t]     = q_q;
    assign valid[t] = vld_q;
  end
endmodule

// File: tb/tb_ram_shift_reg_dual_tap.sv
// tb_ram_shift_reg_dual_tap: scoreboard bench for both tap-change modes driven with one stimulus stream
module tb_ram_shift_reg_dual_tap;
  typedef struct packed {
    logic [7:0] qa;
    logic [7:0] qb;
    logic       va;
    logic       vb;
  } exp_t;
  logic clk = 0, Reset = 0, CE = 0, SCLR = 0, SSET = 0;
  logic [7:0] Din = 0;
  logic [3:0] ADDR_A = 0, ADDR_B = 0;
  logic [7:0] q0a, q0b, q1a, q1b;
  logic v0a, v0b, v1a, v1b;
  int n_chk = 0, n_fail = 0;
  exp_t exp0[$], exp1[$];
  logic [7:0] hist[$];
  logic [7:0] ramp = 0;
  int fill[2][2];
  logic [3:0] areg[2][2];
  logic [7:0] mq[2][2];
  logic mv[2][2];
  always #5 clk = ~clk;
  ram_shift_reg_dual_tap #(.DSIZE(8), .WDEPTH(16), .ADDR_MODE(0)) dut0 (
    .clk(clk), .Reset(Reset), .CE(CE), .SCLR(SCLR), .SSET(SSET), .Din(Din),
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .Q_A(q0a), .Q_B(q0b), .VALID_A(v0a), .VALID_B(v0b));
  ram_shift_reg_dual_tap #(.DSIZE(8), .WDEPTH(16), .ADDR_MODE(1)) dut1 (
    .clk(clk), .Reset(Reset), .CE(CE), .SCLR(SCLR), .SSET(SSET), .Din(Din),
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .Q_A(q1a), .Q_B(q1b), .VALID_A(v1a), .VALID_B(v1b));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int t = 0; t < 2; t++) begin
        fill[m][t] = 0;
        areg[m][t] = 0;
        mq[m][t] = 0;
        mv[m][t] = 0;
      end
  endtask
  // Drive one clock of stimulus, advance the reference model, queue what the DUTs must show after the edge
  task automatic step(input bit ce, input bit sclr, input bit sset, input logic [3:0] a_a, input logic [3:0] a_b);
    logic [7:0] din;
    bit wr, ch;
    int d;
    logic [3:0] a;
    din = ce ? ramp : 8'hAA;
    wr = ce && !sclr && !sset;
    CE = ce; SCLR = sclr; SSET = sset; Din = din; ADDR_A = a_a; ADDR_B = a_b;
    if (wr) begin
      hist.push_back(din);
      ramp++;
    end
    for (int m = 0; m < 2; m++)
      for (int t = 0; t < 2; t++) begin
        a = t ? a_b : a_a;
        d = (a > 15) ? 15 : int'(a);
        ch = (m == 1) && (a != areg[m][t]);
        areg[m][t] = a;
        if (sclr) begin
          mq[m][t] = 0; mv[m][t] = 0; fill[m][t] = 0;
        end else if (ch) begin
          mq[m][t] = sset ? 8'hFF : 8'h00; mv[m][t] = 0; fill[m][t] = 0;
        end else if (sset) begin
          mq[m][t] = 8'hFF;
        end else if (ce) begin
          fill[m][t] = (fill[m][t] >= 16) ? 16 : fill[m][t] + 1;
          mv[m][t] = fill[m][t] > d;
          mq[m][t] = mv[m][t] ? hist[hist.size() - 1 - d] : 8'h00;
        end
      end
    exp0.push_back(exp_t'{mq[0][0], mq[0][1], mv[0][0], mv[0][1]});
    exp1.push_back(exp_t'{mq[1][0], mq[1][1], mv[1][0], mv[1][1]});
    @(negedge clk);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp0.size() > 0) begin
        e = exp0.pop_front();
        chk("m0_Q_A", q0a, e.qa); chk("m0_Q_B", q0b, e.qb);
        chk("m0_VALID_A", v0a, e.va); chk("m0_VALID_B", v0b, e.vb);
      end
      if (exp1.size() > 0) begin
        e = exp1.pop_front();
        chk("m1_Q_A", q1a, e.qa); chk("m1_Q_B", q1b, e.qb);
        chk("m1_VALID_A", v1a, e.va); chk("m1_VALID_B", v1b, e.vb);
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end
  initial begin : stim
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_Q_A", q0a, 0); chk("rst_VALID_A", v0a, 0);
    chk("rst_Q_B", q1b, 0); chk("rst_VALID_B", v1b, 0);
    Reset = 1;
    step(1, 0, 0, 4, 0);
    chk("b0_first_Q", q0b, 0); chk("b0_first_VALID", v0b, 1); chk("a4_not_valid", v0a, 0);
    repeat (3) step(1, 0, 0, 4, 0);
    chk("a4_still_invalid", v0a, 0);
    step(1, 0, 0, 4, 0);
    chk("a4_first_valid", v0a, 1); chk("a4_first_Q", q0a, 0);
    repeat (19) step(1, 0, 0, 4, 0);
    step(1, 0, 0, 15, 0);
    chk("a15_switch_Q", q0a, 9);
    repeat (19) step(1, 0, 0, 15, 0);
    while (ramp != 100) step(1, 0, 0, 4, 0);
    step(1, 0, 0, 15, 0);
    chk("mode0_switch_Q", q0a, 85); chk("mode0_switch_VALID", v0a, 1);
    chk("mode1_flush_VALID", v1a, 0); chk("mode1_flush_Q", q1a, 0);
    repeat (15) step(1, 0, 0, 15, 0);
    chk("mode1_refill_invalid", v1a, 0);
    step(1, 0, 0, 15, 0);
    chk("mode1_refill_VALID", v1a, 1); chk("mode1_refill_Q", q1a, 101);
    chk("mode1_tapB_Q", q1b, 116); chk("mode1_tapB_VALID", v1b, 1);
    repeat (3) step(1, 0, 0, 15, 0);
    step(1, 0, 0, 4, 0);
    chk("mode0_back_Q", q0a, 116);
    repeat (3) step(0, 0, 0, 4, 0);
    chk("ce_hold_Q", q0a, 116);
    step(1, 0, 0, 4, 0);
    chk("ce_resume_Q", q0a, 117);
    step(1, 0, 1, 4, 0);
    chk("sset_Q_A", q0a, 255); chk("sset_Q_B", q0b, 255); chk("sset_VALID", v0a, 1);
    step(1, 0, 0, 4, 0);
    chk("post_sset_Q", q0a, 118);
    step(1, 1, 0, 15, 0);
    chk("sclr_Q", q0a, 0); chk("sclr_VALID_A", v0a, 0); chk("sclr_VALID_B", v0b, 0);
    repeat (15) step(1, 0, 0, 15, 0);
    chk("a15_refill_invalid", v0a, 0);
    step(1, 0, 0, 15, 0);
    chk("a15_refill_VALID", v0a, 1); chk("a15_refill_Q", q0a, 123);
    repeat (10) step(1, 0, 0, 7, 7);
    #3 Reset = 0;
    #1;
    chk("async_Q_A", q0a, 0); chk("async_Q_B", q0b, 0);
    chk("async_VALID_A", v0a, 0); chk("async_VALID_B", v1b, 0);
    model_reset();
    @(negedge clk);
    Reset = 1;
    repeat (8) step(1, 0, 0, 4, 0);
    @(negedge clk);
    chk("queue_drain", exp0.size() + exp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
